// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the control unit and the datapath.
//   - opcode constants (IR[31:27])
//   - control unit state encoding (4 bits, HALT = 0)
//   - IR field positions for the register decoder (Ra, Rb, Rc)
//   - classify(): maps an opcode onto the execute sequence it needs
package cpu_pkg;

  localparam int OPC_WIDTH = 5;

  localparam int IR_OPC_HI = 31;
  localparam int IR_OPC_LO = 27;
  localparam int IR_RA_HI  = 26;
  localparam int IR_RA_LO  = 23;
  localparam int IR_RB_HI  = 22;
  localparam int IR_RB_LO  = 19;
  localparam int IR_RC_HI  = 18;
  localparam int IR_RC_LO  = 15;

  localparam logic [OPC_WIDTH-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_WIDTH-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_WIDTH-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPC_WIDTH-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPC_WIDTH-1:0] OPC_SHR  = 5'b00111;
  localparam logic [OPC_WIDTH-1:0] OPC_SHL  = 5'b01000;
  localparam logic [OPC_WIDTH-1:0] OPC_ROR  = 5'b01001;
  localparam logic [OPC_WIDTH-1:0] OPC_ROL  = 5'b01010;
  localparam logic [OPC_WIDTH-1:0] OPC_MUL  = 5'b01111;
  localparam logic [OPC_WIDTH-1:0] OPC_DIV  = 5'b10000;
  localparam logic [OPC_WIDTH-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_WIDTH-1:0] OPC_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_HALT = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T1W  = 4'd3,
    ST_T2   = 4'd4,
    ST_T3   = 4'd5,
    ST_T4   = 4'd6,
    ST_T5   = 4'd7,
    ST_T6   = 4'd8
  } cu_state_e;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_MULDIV  = 3'd1,
    CLS_NOP     = 3'd2,
    CLS_HALT    = 3'd3,
    CLS_ILLEGAL = 3'd4
  } opc_class_e;

  function automatic opc_class_e classify(input logic [OPC_WIDTH-1:0] opc);
    opc_class_e cls;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_SHR, OPC_SHL, OPC_ROR, OPC_ROL: cls = CLS_ALU;
      OPC_MUL, OPC_DIV:                   cls = CLS_MULDIV;
      OPC_NOP:                            cls = CLS_NOP;
      OPC_HALT:                           cls = CLS_HALT;
      default:                            cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: bundle between the control unit and the single-bus datapath.
//   ir, mem_ready           : datapath/memory -> control unit
//   *out strobes            : bus drive enables
//   *in strobes             : register load enables
//   IncPC, Read             : PC+1 ALU mode, memory read request
//   Gra/Grb/Grc/Rin/Rout    : register-field select and encode strobes
//   alu_op                  : ALU operation (opcode during T4, else 0)
// Handshake: mem_ready is a level qualifier, not a valid/ready pair. The
// control unit holds Read high from T1 until the cycle mem_ready is seen high;
// memory data is taken into MDR on that same cycle (MDRin is high throughout).
interface control_unit_if #(parameter int OPC_W = 5) ();
  logic [31:0]      ir;
  logic             mem_ready;
  logic             PCout, Zlowout, Zhighout, MDRout;
  logic             MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic             IncPC, Read;
  logic             Gra, Grb, Grc, Rin, Rout;
  logic [OPC_W-1:0] alu_op;

  modport master (
    input  ir, mem_ready,
    output PCout, Zlowout, Zhighout, MDRout,
    output MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
    output IncPC, Read,
    output Gra, Grb, Grc, Rin, Rout,
    output alu_op
  );

  modport slave (
    output ir, mem_ready,
    input  PCout, Zlowout, Zhighout, MDRout,
    input  MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
    input  IncPC, Read,
    input  Gra, Grb, Grc, Rin, Rout,
    input  alu_op
  );
endinterface

// File: rtl/cu_wait_timer.sv
// cu_wait_timer: counts fetch wait cycles and latches the fetch-timeout fault.
//   clk, clr     : clock, async active-high reset
//   in_t1        : FSM is in T1 (counter loads 1 if memory is not ready)
//   in_t1w       : FSM is in T1W (counter advances while memory is not ready)
//   mem_ready    : memory read data valid this cycle
//   clear_fault  : start request, clears the sticky fault
//   at_limit     : counter has reached WAIT_TIMEOUT (registered compare)
//   mem_fault    : sticky fault flag
module cu_wait_timer #(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic in_t1,
  input  logic in_t1w,
  input  logic mem_ready,
  input  logic clear_fault,
  output logic at_limit,
  output logic mem_fault
);

  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             expire;

  assign at_limit = (cnt_q == CNT_W'(WAIT_TIMEOUT));
  // Expiry happens only in a T1W cycle that still has no data.
  assign expire   = in_t1w && !mem_ready && at_limit;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (in_t1 && !mem_ready) begin
      cnt_q <= CNT_W'(1);
    end else if (in_t1w && !mem_ready && !at_limit) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mem_fault <= 1'b0;
    end else if (expire) begin
      mem_fault <= 1'b1;
    end else if (clear_fault) begin
      mem_fault <= 1'b0;
    end
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: hard-wired Moore sequencer for the single-bus datapath.
// Fetch (T0-T2, with T1W wait states), decode in T3, execute T4-T6 for
// register-register ALU ops and MUL/DIV into HI/LO.
//   clk, clr    : clock, async active-high reset (forces HALT)
//   start, stop : run control (stop takes effect at the next instruction end)
//   bus         : control_unit_if master (ir, mem_ready in; strobes out)
//   run         : high whenever not in HALT
//   mem_fault   : sticky fetch-timeout fault
//   illegal_op  : one-cycle pulse in T3 for an unlisted opcode
//   state_dbg   : current FSM state (cu_state_e encoding)
//   instr_count : completed-instruction counter, present only when
//                 CU_INSTR_COUNT_EN is defined
// Outputs depend only on the state register, the fault flop and ir.
module control_unit
  import cpu_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16,
  parameter int OPC_W        = OPC_WIDTH
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                stop,
  control_unit_if.master      bus,
  output logic                run,
  output logic                mem_fault,
  output logic                illegal_op,
  output logic [3:0]          state_dbg
`ifdef CU_INSTR_COUNT_EN
  ,
  output logic [31:0]         instr_count
`endif
);

  cu_state_e        state_q, state_d;
  logic [OPC_W-1:0] opc;
  opc_class_e       cls;
  cu_state_e        end_target;
  logic             stop_pend_q;
  logic             at_limit;
  logic             unused_ir_fields;

  assign opc = bus.ir[IR_OPC_HI:IR_OPC_LO];
  assign cls = classify(opc);

  // Register fields are decoded by the datapath via Gra/Grb/Grc.
  assign unused_ir_fields = ^{bus.ir[IR_RA_HI:IR_RA_LO], bus.ir[IR_RB_HI:IR_RB_LO],
                              bus.ir[IR_RC_HI:IR_RC_LO], bus.ir[IR_RC_LO-1:0]};

  // Where a finished instruction goes: a pending stop turns it into HALT.
  assign end_target = stop_pend_q ? ST_HALT : ST_T0;

  cu_wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_wait_timer (
    .clk         (clk),
    .clr         (clr),
    .in_t1       (state_q == ST_T1),
    .in_t1w      (state_q == ST_T1W),
    .mem_ready   (bus.mem_ready),
    .clear_fault (start),
    .at_limit    (at_limit),
    .mem_fault   (mem_fault)
  );

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_HALT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: if (start) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = bus.mem_ready ? ST_T2 : ST_T1W;
      ST_T1W: begin
        if (bus.mem_ready)  state_d = ST_T2;
        else if (at_limit)  state_d = ST_HALT;
      end
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        case (cls)
          CLS_ALU, CLS_MULDIV: state_d = ST_T4;
          CLS_HALT:            state_d = ST_HALT;
          default:             state_d = end_target;  // NOP and illegal
        endcase
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = (cls == CLS_MULDIV) ? ST_T6 : end_target;
      ST_T6:   state_d = end_target;
      default: state_d = ST_HALT;
    endcase
  end

  // Stop request: recorded every cycle outside HALT, consumed on entry to
  // HALT. In HALT only a stop that arrives together with start is kept.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stop_pend_q <= 1'b0;
    end else if (state_q == ST_HALT) begin
      stop_pend_q <= start && stop;
    end else if (state_d == ST_HALT) begin
      stop_pend_q <= 1'b0;
    end else begin
      stop_pend_q <= stop_pend_q || stop;
    end
  end

  // Outputs
  always_comb begin
    bus.PCout    = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.MDRout   = 1'b0;
    bus.MARin    = 1'b0;
    bus.PCin     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.Rin      = 1'b0;
    bus.Rout     = 1'b0;
    bus.alu_op   = '0;
    case (state_q)
      ST_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      ST_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      ST_T1W: begin
        // PC already holds PC+1; only keep the read going.
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
      end
      ST_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      ST_T3: begin
        if (cls == CLS_ALU) begin
          bus.Grb  = 1'b1;
          bus.Rout = 1'b1;
          bus.Yin  = 1'b1;
        end else if (cls == CLS_MULDIV) begin
          bus.Gra  = 1'b1;
          bus.Rout = 1'b1;
          bus.Yin  = 1'b1;
        end
      end
      ST_T4: begin
        bus.Grc    = (cls == CLS_ALU);
        bus.Grb    = (cls == CLS_MULDIV);
        bus.Rout   = 1'b1;
        bus.Zin    = 1'b1;
        bus.alu_op = opc;
      end
      ST_T5: begin
        bus.Zlowout = 1'b1;
        if (cls == CLS_MULDIV) begin
          bus.LOin = 1'b1;
        end else begin
          bus.Gra = 1'b1;
          bus.Rin = 1'b1;
        end
      end
      ST_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign run        = (state_q != ST_HALT);
  assign illegal_op = (state_q == ST_T3) && (cls == CLS_ILLEGAL);
  assign state_dbg  = state_q;

`ifdef CU_INSTR_COUNT_EN
  logic instr_done;

  // An instruction completes when T3/T5/T6 hands over to T0 or HALT.
  assign instr_done = ((state_q == ST_T3) || (state_q == ST_T5) || (state_q == ST_T6)) &&
                      ((state_d == ST_T0) || (state_d == ST_HALT));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      instr_count <= '0;
    end else if (instr_done) begin
      instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed bench for control_unit (WAIT_TIMEOUT = 4).
// Expected output words are queued as stimulus is driven and popped and
// compared one cycle at a time, #1 after each rising edge.
module tb_control_unit;
  import cpu_pkg::*;

  // Output word layout (MSB..LSB)
  localparam logic [26:0] PCOUT    = 27'd1 << 26;
  localparam logic [26:0] ZLOWOUT  = 27'd1 << 25;
  localparam logic [26:0] ZHIGHOUT = 27'd1 << 24;
  localparam logic [26:0] MDROUT   = 27'd1 << 23;
  localparam logic [26:0] MARIN    = 27'd1 << 22;
  localparam logic [26:0] PCIN     = 27'd1 << 21;
  localparam logic [26:0] MDRIN    = 27'd1 << 20;
  localparam logic [26:0] IRIN     = 27'd1 << 19;
  localparam logic [26:0] YIN      = 27'd1 << 18;
  localparam logic [26:0] ZIN      = 27'd1 << 17;
  localparam logic [26:0] HIIN     = 27'd1 << 16;
  localparam logic [26:0] LOIN     = 27'd1 << 15;
  localparam logic [26:0] INCPC    = 27'd1 << 14;
  localparam logic [26:0] READ     = 27'd1 << 13;
  localparam logic [26:0] GRA      = 27'd1 << 12;
  localparam logic [26:0] GRB      = 27'd1 << 11;
  localparam logic [26:0] GRC      = 27'd1 << 10;
  localparam logic [26:0] RIN      = 27'd1 << 9;
  localparam logic [26:0] ROUT     = 27'd1 << 8;
  localparam logic [26:0] RUN      = 27'd1 << 2;
  localparam logic [26:0] FAULT    = 27'd1 << 1;
  localparam logic [26:0] ILLEGAL  = 27'd1 << 0;

  localparam logic [26:0] W_T0  = PCOUT | MARIN | INCPC | ZIN | RUN;
  localparam logic [26:0] W_T1  = ZLOWOUT | PCIN | READ | MDRIN | RUN;
  localparam logic [26:0] W_T1W = READ | MDRIN | RUN;
  localparam logic [26:0] W_T2  = MDROUT | IRIN | RUN;

  localparam logic [31:0] IR_AND  = 32'h28918000;
  localparam logic [31:0] IR_MUL  = 32'h78880000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_ILL  = 32'hF8000000;
  localparam logic [31:0] IR_ADD  = 32'h18A30000;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        stop;
  logic        run;
  logic        mem_fault;
  logic        illegal_op;
  logic [3:0]  state_dbg;
`ifdef CU_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  control_unit_if #(.OPC_W(5)) cif ();

  control_unit #(.WAIT_TIMEOUT(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .stop       (stop),
    .bus        (cif.master),
    .run        (run),
    .mem_fault  (mem_fault),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
`ifdef CU_INSTR_COUNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  logic [26:0] obs;
  assign obs = {cif.PCout, cif.Zlowout, cif.Zhighout, cif.MDRout, cif.MARin, cif.PCin,
                cif.MDRin, cif.IRin, cif.Yin, cif.Zin, cif.HIin, cif.LOin, cif.IncPC,
                cif.Read, cif.Gra, cif.Grb, cif.Grc, cif.Rin, cif.Rout, cif.alu_op,
                run, mem_fault, illegal_op};

  // Scoreboard
  logic [26:0] exp_q[$];
  string       tag_q[$];
  int          total_cnt = 0;
  int          pass_cnt  = 0;

  function automatic logic [26:0] alu(input logic [4:0] o);
    return {19'd0, o, 3'd0};
  endfunction

  task automatic push(input logic [26:0] w, input string t);
    exp_q.push_back(w);
    tag_q.push_back(t);
  endtask

  task automatic check_head();
    logic [26:0] e;
    string       t;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_underflow: observed %h required an expected entry", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) pass_cnt++;
      else $error("FAIL %s: observed %h required %h", t, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_head();
  endtask

  task automatic drain();
    while (exp_q.size() > 0) tick();
  endtask

`ifdef CU_INSTR_COUNT_EN
  task automatic check_cnt(input logic [31:0] e, input string t);
    total_cnt++;
    assert (instr_count === e) pass_cnt++;
    else $error("FAIL %s: observed %0d required %0d", t, instr_count, e);
  endtask
`endif

  initial begin
    clr = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cif.mem_ready = 1'b1;
    cif.ir = IR_AND;

    // Reset state
    #12;
    push(27'd0, "reset_outputs");
    check_head();
`ifdef CU_INSTR_COUNT_EN
    check_cnt(32'd0, "reset_count");
`endif
    clr = 1'b0;
    push(27'd0, "halt_idle");
    tick();

    // AND R1,R2,R3: T0..T5, back to T0
    start = 1'b1;
    push(W_T0, "and_t0");
    tick();
    start = 1'b0;
    push(W_T1, "and_t1");
    push(W_T2, "and_t2");
    push(GRB | ROUT | YIN | RUN, "and_t3");
    push(GRC | ROUT | ZIN | RUN | alu(5'b00101), "and_t4");
    push(ZLOWOUT | GRA | RIN | RUN, "and_t5");
    push(W_T0, "and_next_t0");
    drain();

    // MUL R1,R1: T5 to LO, T6 to HI, no Rin
    cif.ir = IR_MUL;
    push(W_T1, "mul_t1");
    push(W_T2, "mul_t2");
    push(GRA | ROUT | YIN | RUN, "mul_t3");
    push(GRB | ROUT | ZIN | RUN | alu(5'b01111), "mul_t4");
    push(ZLOWOUT | LOIN | RUN, "mul_t5");
    push(ZHIGHOUT | HIIN | RUN, "mul_t6");
    push(W_T0, "mul_next_t0");
    drain();

    // NOP
    cif.ir = IR_NOP;
    push(W_T1, "nop_t1");
    push(W_T2, "nop_t2");
    push(RUN, "nop_t3");
    push(W_T0, "nop_next_t0");
    drain();

    // Illegal opcode 11111: one-cycle pulse, behaves as NOP
    cif.ir = IR_ILL;
    push(W_T1, "ill_t1");
    push(W_T2, "ill_t2");
    push(RUN | ILLEGAL, "ill_t3");
    push(W_T0, "ill_next_t0");
    drain();

    // ADD with stop pulse in T3: completes T5, then HALT
    cif.ir = IR_ADD;
    push(W_T1, "add_t1");
    push(W_T2, "add_t2");
    push(GRB | ROUT | YIN | RUN, "add_t3");
    drain();
    stop = 1'b1;
    push(GRC | ROUT | ZIN | RUN | alu(5'b00011), "add_t4");
    tick();
    stop = 1'b0;
    push(ZLOWOUT | GRA | RIN | RUN, "add_t5");
    push(27'd0, "add_stop_halt");
    drain();

    // stop in HALT is ignored: the next NOP returns to T0
    stop = 1'b1;
    push(27'd0, "stop_in_halt");
    tick();
    stop = 1'b0;
    start = 1'b1;
    cif.ir = IR_NOP;
    push(W_T0, "restart_t0");
    tick();
    start = 1'b0;
    push(W_T1, "nop2_t1");
    push(W_T2, "nop2_t2");
    push(RUN, "nop2_t3");
    push(W_T0, "nop2_no_halt_t0");
    drain();

    // Fetch timeout: T1, four T1W, then HALT with fault
    cif.mem_ready = 1'b0;
    push(W_T1, "to_t1");
    for (int i = 0; i < 4; i++) push(W_T1W, "to_t1w");
    push(FAULT, "to_fault_halt");
    push(FAULT, "to_fault_sticky");
    drain();

    // start clears the fault; HALT opcode stops the sequencer
    cif.mem_ready = 1'b1;
    cif.ir = IR_HALT;
    start = 1'b1;
    push(W_T0, "fault_cleared_t0");
    tick();
    start = 1'b0;
    push(W_T1, "halt_t1");
    push(W_T2, "halt_t2");
    push(RUN, "halt_t3");
    push(27'd0, "halt_op_halt");
    drain();

    // start and stop together: start wins, stop pending ends the next instr
    cif.ir = IR_NOP;
    start = 1'b1;
    stop = 1'b1;
    push(W_T0, "ss_t0");
    tick();
    start = 1'b0;
    stop = 1'b0;
    push(W_T1, "ss_t1");
    push(W_T2, "ss_t2");
    push(RUN, "ss_t3");
    push(27'd0, "ss_pending_halt");
    drain();

    // clr mid-T4 aborts asynchronously
    cif.ir = IR_AND;
    start = 1'b1;
    push(W_T0, "clr_t0");
    tick();
    start = 1'b0;
    push(W_T1, "clr_t1");
    push(W_T2, "clr_t2");
    push(GRB | ROUT | YIN | RUN, "clr_t3");
    push(GRC | ROUT | ZIN | RUN | alu(5'b00101), "clr_t4");
    drain();
    #2;
    clr = 1'b1;
    #1;
    push(27'd0, "clr_async_zero");
    check_head();
`ifdef CU_INSTR_COUNT_EN
    check_cnt(32'd0, "clr_count_zero");
`endif
    #1;
    clr = 1'b0;
    push(27'd0, "after_clr_halt");
    tick();

    // AND, NOP, HALT after reset
    start = 1'b1;
    push(W_T0, "cnt_t0");
    tick();
    start = 1'b0;
    push(W_T1, "cnt_and_t1");
    push(W_T2, "cnt_and_t2");
    push(GRB | ROUT | YIN | RUN, "cnt_and_t3");
    push(GRC | ROUT | ZIN | RUN | alu(5'b00101), "cnt_and_t4");
    push(ZLOWOUT | GRA | RIN | RUN, "cnt_and_t5");
    push(W_T0, "cnt_and_next");
    drain();
    cif.ir = IR_NOP;
    push(W_T1, "cnt_nop_t1");
    push(W_T2, "cnt_nop_t2");
    push(RUN, "cnt_nop_t3");
    push(W_T0, "cnt_nop_next");
    drain();
    cif.ir = IR_HALT;
    push(W_T1, "cnt_halt_t1");
    push(W_T2, "cnt_halt_t2");
    push(RUN, "cnt_halt_t3");
    push(27'd0, "cnt_halted");
    drain();
`ifdef CU_INSTR_COUNT_EN
    check_cnt(32'd3, "instr_count_3");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hard-wired Moore sequencer that drives the single-bus `datapath` control strobes, replacing hand-written testbench state sequences.
- Performs instruction fetch (T0–T2), decodes IR opcode and register fields, and sequences execute steps for register-register ALU ops and MUL/DIV (HI/LO).
- Has a memory-ready handshake with timeout, plus start/stop run control.
- Sits between the IR output and every datapath control input.

Parameters:
- WAIT_TIMEOUT, 16, max cycles spent waiting for mem_ready in a fetch before a fault halt (≥1).
- OPC_W, 5, opcode width; IR[31:27].

Ports:
- clk  in  1  system clock, rising-edge.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  leave HALT and begin fetching.
- stop  in  1  finish current instruction, then HALT.
- ir  in  32  instruction register contents; opcode IR[31:27].
- mem_ready  in  1  memory read data valid this cycle.
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus drive strobes.
- MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register load strobes.
- IncPC, Read  out  1 each  PC+1 ALU mode; memory read request.
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-field select and encode strobes for the datapath register decoder.
- alu_op  out  5  ALU operation; equals the opcode during T4, else 0.
- run  out  1  high whenever not in HALT.
- mem_fault  out  1  sticky; set on fetch timeout, cleared by clr or start.
- illegal_op  out  1  one-cycle pulse on decode of an unlisted opcode.

Behaviour:
- States: HALT, T0, T1, T1W, T2, T3, T4, T5, T6.
- clr forces HALT asynchronously. All outputs are 0 during and after reset, including run, mem_fault and the counter.
- Outputs decode only from the state register and ir. There is no combinational path from start, stop or mem_ready to any output.
- HALT: all strobes 0. start → T0 next cycle.
- T0: PCout, MARin, IncPC, Zin. → T1.
- T1: Zlowout, PCin, Read, MDRin.
  - mem_ready=1 → T2.
  - else → T1W and load the wait counter with 1.
- T1W: Read, MDRin only (PC is not re-loaded).
  - mem_ready=1 → T2.
  - counter==WAIT_TIMEOUT → HALT, set mem_fault.
  - else increment the counter.
- T2: MDRout, IRin. → T3. The opcode is decoded in T3 from the updated ir.
- T3 decode:
  - ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000, ROR 01001, ROL 01010: Grb, Rout, Yin. → T4.
  - MUL 01111, DIV 10000: Gra, Rout, Yin. → T4.
  - NOP 11010: no strobes. → T0.
  - HALT 11011: no strobes. → HALT.
  - Any other opcode: pulse illegal_op, treat as NOP.
- T4:
  - ALU ops: Grc, Rout, Zin, alu_op=opcode. → T5.
  - MUL/DIV: Grb, Rout, Zin, alu_op=opcode. → T5.
- T5:
  - ALU ops: Zlowout, Gra, Rin. → T0.
  - MUL/DIV: Zlowout, LOin. → T6.
- T6: Zhighout, HIin. → T0.
- stop handling:
  - stop is sampled every cycle into a pending flag.
  - At each instruction end (the state that would go to T0) with the flag set, go to HALT and clear the flag.
  - stop while already in HALT has no effect.
- Simultaneous start and stop in HALT: start wins, and the stop is recorded as pending.
- Latency: ALU op = 6 cycles, MUL/DIV = 7 cycles, NOP = 4 cycles, each plus any T1W cycles.
- clr mid-instruction aborts immediately; there is no partial write-back beyond strobes already issued.

Optional Feature:
- CU_INSTR_COUNT_EN
- When defined:
  - Adds output instr_count [31:0], reset to 0.
  - Increments once per completed instruction (transition into T0 or HALT from T3/T5/T6), including NOP and HALT opcodes.
  - Wraps from 0xFFFFFFFF to 0.
- When undefined: the port and the counter are absent.

Decomposition:
- cpu_pkg: opcode localparams (OPC_ADD … OPC_HALT), state encoding (4-bit, HALT=0), IR field positions (Ra 26:23, Rb 22:19, Rc 18:15).
- The datapath also imports cpu_pkg for its alu_op decoding.
- One sub-module, cu_wait_timer: counter, WAIT_TIMEOUT compare, mem_fault latch.

Test Plan:
- clr pulse mid-T4, then start: all outputs 0 asynchronously. After start, T0 shows PCout=MARin=IncPC=Zin=1.
- ir=0x28918000 (AND R1,R2,R3), mem_ready tied 1: sequence T0..T5 in 6 cycles.
  - T3 Grb+Rout+Yin, T4 Grc+Rout+Zin with alu_op=00101, T5 Zlowout+Gra+Rin.
  - Returns to T0.
- ir=0x78880000 (MUL R1,R1): T5 Zlowout+LOin, T6 Zhighout+HIin, no Rin asserted. 7 cycles.
- mem_ready held 0 with WAIT_TIMEOUT=4: T1 then 4 T1W cycles with Read=1 and PCin=0 after T1, then HALT with mem_fault=1 and run=0. start clears mem_fault.
- stop pulse during T3 of ADD: the instruction completes T5, then HALT. Opcode 11111 gives a 1-cycle illegal_op pulse and returns to T0 after T3.
- With CU_INSTR_COUNT_EN: 3 instructions (AND, NOP, HALT) → instr_count=3, run=0.
